// File: rtl/unary_matmul_engine.sv
// unary_matmul_engine
//   Weight-stationary K x N array computing C = A x B (or C += A x B) for a
//   signed M x K matrix A and a signed K x N matrix B. Each A element is
//   replayed as a thermometer pulse train of its magnitude over a W-cycle
//   window. Each node adds its signed B magnitude once per pulse. Partial
//   sums drop one row per window, and the bottom row produces C.
//
// Ports
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   start  : job request, accepted only while idle
//   acc    : sampled with start; 1 = add result to held C, 0 = overwrite C
//   a_in   : A[m][k] at bits [(m*K+k)*BW +: BW]
//   b_in   : B[k][n] at bits [(k*N+n)*BW +: BW]
//   busy   : high while a job is in flight
//   done   : one-cycle pulse when c_out holds the finished result
//   c_out  : C[m][n] at bits [(m*N+n)*OUT_W +: OUT_W]; held between jobs
module unary_matmul_engine #(
  parameter  int M     = 2,
  parameter  int K     = 2,
  parameter  int N     = 2,
  parameter  int BW    = 4,
  localparam int W     = 2 ** (BW - 1),
  localparam int OUT_W = 2 * BW + $clog2(K),
  localparam int LAT   = (M + K + N - 2) * W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 acc,
  input  logic [M*K*BW-1:0]    a_in,
  input  logic [K*N*BW-1:0]    b_in,
  output logic                 busy,
  output logic                 done,
  output logic [M*N*OUT_W-1:0] c_out
);

  localparam int NWIN  = M + K + N - 2;
  localparam int WIN_W = $clog2(NWIN + 1);
  localparam int CNT_W = $clog2(LAT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  // |v| as an unsigned BW-bit value, so the most negative code maps to W.
  function automatic logic [BW-1:0] mag_of(input logic [BW-1:0] v);
    logic [BW-1:0] neg_v;
    neg_v = ~v + 1'b1;
    return v[BW-1] ? neg_v : v;
  endfunction

  // Signed per-cycle contribution of one node.
  function automatic logic signed [OUT_W-1:0] term(input logic pulse,
                                                   input logic neg,
                                                   input logic [BW-1:0] bmag);
    logic signed [OUT_W-1:0] ext;
    ext = $signed({{(OUT_W-BW){1'b0}}, bmag});
    if (!pulse) return '0;
    return neg ? -ext : ext;
  endfunction

  // Result write-back: overwrite or accumulate, wrapping at OUT_W bits.
  function automatic logic [OUT_W-1:0] merge(input logic add,
                                             input logic [OUT_W-1:0] old,
                                             input logic signed [OUT_W-1:0] val);
    return add ? old + val : val;
  endfunction

  state_t               state;
  logic [M*K*BW-1:0]    a_q;
  logic [K*N*BW-1:0]    b_q;
  logic                 acc_q;
  logic [BW-1:0]        cyc;
  logic [WIN_W-1:0]     win;
  logic [CNT_W-1:0]     run_cnt;

  logic [BW-1:0]           amag_p0     [K][N];
  logic                    asgn_p0     [K][N];
  logic signed [OUT_W-1:0] node_acc_p1 [K][N];
  logic signed [OUT_W-1:0] psum_p1     [K][N];
  logic                    vld_p2;
  logic [WIN_W-1:0]        wr_win_p2;

  logic [M*K*BW-1:0]       a_sel;
  int                      src_win;
  logic [BW-1:0]           src_mag  [K];
  logic                    src_sgn  [K];
  logic [BW-1:0]           bmag     [K][N];
  logic                    bsgn     [K][N];
  logic signed [OUT_W-1:0] psum_in  [K][N];
  logic signed [OUT_W-1:0] node_term[K][N];
  logic signed [OUT_W-1:0] node_sum [K][N];

  logic win_live;
  logic last_cyc;

  assign win_live = (win < WIN_W'(NWIN));
  assign last_cyc = (cyc == BW'(W - 1));

  // Stage p0: column-0 stream source for the window about to start.
  // On the accept edge the operands are taken straight from a_in.
  always_comb begin
    a_sel   = (state == S_IDLE) ? a_in : a_q;
    src_win = (state == S_IDLE) ? 0 : int'(win) + 1;
    for (int k = 0; k < K; k++) begin
      src_mag[k] = '0;
      src_sgn[k] = 1'b0;
      for (int m = 0; m < M; m++) begin
        if (m + k == src_win) begin
          src_mag[k] = mag_of(a_sel[(m*K+k)*BW +: BW]);
          src_sgn[k] = a_sel[(m*K+k)*BW + BW - 1];
        end
      end
    end
  end

  // Stage p1: per-node unary AND, sign correction and partial-sum chain.
  always_comb begin
    for (int n = 0; n < N; n++) begin
      psum_in[0][n] = '0;
      for (int k = 1; k < K; k++) psum_in[k][n] = psum_p1[k-1][n];
    end
    for (int k = 0; k < K; k++) begin
      for (int n = 0; n < N; n++) begin
        bmag[k][n]      = mag_of(b_q[(k*N+n)*BW +: BW]);
        bsgn[k][n]      = b_q[(k*N+n)*BW + BW - 1];
        node_term[k][n] = term(cyc < amag_p0[k][n],
                               (asgn_p0[k][n] ^ bsgn[k][n]) &&
                               (amag_p0[k][n] != '0) && (bmag[k][n] != '0),
                               bmag[k][n]);
        node_sum[k][n]  = psum_in[k][n] + node_acc_p1[k][n] + node_term[k][n];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      c_out     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= 1'b0;
      cyc       <= '0;
      win       <= '0;
      run_cnt   <= '0;
      vld_p2    <= 1'b0;
      wr_win_p2 <= '0;
      for (int k = 0; k < K; k++) begin
        for (int n = 0; n < N; n++) begin
          amag_p0[k][n]     <= '0;
          asgn_p0[k][n]     <= 1'b0;
          node_acc_p1[k][n] <= '0;
          psum_p1[k][n]     <= '0;
        end
      end
    end else begin
      done   <= 1'b0;
      vld_p2 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            a_q     <= a_in;
            b_q     <= b_in;
            acc_q   <= acc;
            cyc     <= '0;
            win     <= '0;
            run_cnt <= '0;
            for (int k = 0; k < K; k++) begin
              for (int n = 0; n < N; n++) begin
                amag_p0[k][n]     <= (n == 0) ? src_mag[k] : '0;
                asgn_p0[k][n]     <= (n == 0) ? src_sgn[k] : 1'b0;
                node_acc_p1[k][n] <= '0;
                psum_p1[k][n]     <= '0;
              end
            end
          end
        end
        S_RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (win_live) begin
            if (last_cyc) begin
              // Window boundary: hand sums down, shift A one column right.
              cyc       <= '0;
              win       <= win + 1'b1;
              vld_p2    <= 1'b1;
              wr_win_p2 <= win;
              for (int k = 0; k < K; k++) begin
                amag_p0[k][0] <= src_mag[k];
                asgn_p0[k][0] <= src_sgn[k];
                for (int n = 1; n < N; n++) begin
                  amag_p0[k][n] <= amag_p0[k][n-1];
                  asgn_p0[k][n] <= asgn_p0[k][n-1];
                end
                for (int n = 0; n < N; n++) begin
                  node_acc_p1[k][n] <= '0;
                  psum_p1[k][n]     <= node_sum[k][n];
                end
              end
            end else begin
              cyc <= cyc + 1'b1;
              for (int k = 0; k < K; k++)
                for (int n = 0; n < N; n++)
                  node_acc_p1[k][n] <= node_acc_p1[k][n] + node_term[k][n];
            end
          end
          // Stage p2: bottom-row sum of window m+K-1+n lands in C[m][n].
          if (vld_p2) begin
            for (int n = 0; n < N; n++) begin
              for (int m = 0; m < M; m++) begin
                if (m + K - 1 + n == int'(wr_win_p2))
                  c_out[(m*N+n)*OUT_W +: OUT_W] <=
                    merge(acc_q, c_out[(m*N+n)*OUT_W +: OUT_W], psum_p1[K-1][n]);
              end
            end
          end
          if (run_cnt == CNT_W'(LAT - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unary_matmul_engine.sv
// tb_unary_matmul_engine
//   Directed bench for unary_matmul_engine: a 2x2x2 instance for the main
//   sequence and a 3x2x1 instance for the rectangular/zero-operand case.
module tb_unary_matmul_engine;

  localparam int OW = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic            start, acc;
  logic [15:0]     a_in, b_in;
  logic            busy, done;
  logic [4*OW-1:0] c_out;

  logic            start_r, acc_r;
  logic [23:0]     a_r;
  logic [7:0]      b_r;
  logic            busy_r, done_r;
  logic [3*OW-1:0] c_r;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  unary_matmul_engine #(.M(2), .K(2), .N(2), .BW(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .acc(acc),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .c_out(c_out)
  );

  unary_matmul_engine #(.M(3), .K(2), .N(1), .BW(4)) u_rect (
    .clk(clk), .reset(reset), .start(start_r), .acc(acc_r),
    .a_in(a_r), .b_in(b_r), .busy(busy_r), .done(done_r), .c_out(c_r)
  );

  // A/B packing: element 0 in the low nibble.
  localparam logic [15:0] BA = {4'h4, 4'h3, 4'h2, 4'h1};  // [[1,2],[3,4]]
  localparam logic [15:0] BB = {4'h8, 4'h7, 4'h6, 4'h5};  // [[5,6],[7,-8]]
  localparam logic [15:0] AN = 16'h8888;                  // all -8
  localparam logic [15:0] B7 = 16'h7777;                  // all 7

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int cel(input int idx);
    logic signed [OW-1:0] v;
    v = c_out[idx*OW +: OW];
    return int'(v);
  endfunction

  function automatic int celr(input int idx);
    logic signed [OW-1:0] v;
    v = c_r[idx*OW +: OW];
    return int'(v);
  endfunction

  task automatic check_c(input string tag, input int e00, input int e01,
                         input int e10, input int e11);
    check({tag, "_c00"}, cel(0), e00);
    check({tag, "_c01"}, cel(1), e01);
    check({tag, "_c10"}, cel(2), e10);
    check({tag, "_c11"}, cel(3), e11);
  endtask

  // Called on a negedge; start is seen by exactly one rising edge.
  task automatic drive_start(input logic [15:0] a, input logic [15:0] b,
                             input logic accv);
    a_in  = a;
    b_in  = b;
    acc   = accv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    acc   = ~accv;
  endtask

  // Waits (bounded) for done; optionally pulses start at busy cycle pulse_at.
  task automatic wait_done(input int pulse_at, input logic [15:0] pa,
                           input logic [15:0] pb, output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
      if (i == pulse_at) begin
        a_in  = pa;
        b_in  = pb;
        acc   = 1'b1;
        start = 1'b1;
      end
    end
  endtask

  initial begin
    int lat, bcnt, dn;
    reset   = 1'b1;
    start   = 1'b0;
    acc     = 1'b0;
    a_in    = '0;
    b_in    = '0;
    start_r = 1'b0;
    acc_r   = 1'b0;
    a_r     = '0;
    b_r     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check_c("rst", 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic product
    drive_start(BA, BB, 1'b0);
    wait_done(0, '0, '0, lat, bcnt);
    check("basic_lat", lat, 33);
    check("basic_busy_cycles", bcnt, 33);
    check_c("basic", 19, -10, 43, -14);
    @(negedge clk);
    check("basic_done_pulse", int'(done), 0);
    check("basic_idle", int'(busy), 0);

    // Accumulate, then overwrite again
    drive_start(BA, BB, 1'b1);
    wait_done(0, '0, '0, lat, bcnt);
    check("accum_lat", lat, 33);
    check_c("accum", 38, -20, 86, -28);
    drive_start(BA, BB, 1'b0);
    wait_done(0, '0, '0, lat, bcnt);
    check_c("overwrite", 19, -10, 43, -14);

    // Extreme operands
    drive_start(AN, AN, 1'b0);
    wait_done(0, '0, '0, lat, bcnt);
    check("neg8sq_lat", lat, 33);
    check_c("neg8sq", 128, 128, 128, 128);
    drive_start(AN, B7, 1'b0);
    wait_done(0, '0, '0, lat, bcnt);
    check_c("neg8x7", -112, -112, -112, -112);

    // start while busy is ignored; start in the done cycle is accepted
    drive_start(BA, BB, 1'b0);
    wait_done(10, AN, AN, lat, bcnt);
    check("ignore_lat", lat, 33);
    check_c("ignore", 19, -10, 43, -14);
    drive_start(AN, B7, 1'b0);
    wait_done(0, '0, '0, lat, bcnt);
    check("b2b_lat", lat, 33);
    check("b2b_busy_cycles", bcnt, 33);
    check_c("b2b", -112, -112, -112, -112);

    // Reset mid-job
    drive_start(BA, BB, 1'b1);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check_c("abort", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_stays_idle", int'(busy), 0);
    drive_start(BA, BB, 1'b1);
    wait_done(0, '0, '0, lat, bcnt);
    check("fresh_lat", lat, 33);
    check_c("fresh", 19, -10, 43, -14);

    // Rectangular 3x2x1 with zero rows: A=[[0,0],[1,-1],[-8,7]], B=[[3],[3]]
    a_r     = {4'h7, 4'h8, 4'hF, 4'h1, 4'h0, 4'h0};
    b_r     = {4'h3, 4'h3};
    acc_r   = 1'b0;
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    a_r     = '1;
    b_r     = '1;
    lat     = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done_r) begin
        lat = i;
        break;
      end
    end
    check("rect_lat", lat, 33);
    check("rect_c0", celr(0), 0);
    check("rect_c1", celr(1), 0);
    check("rect_c2", celr(2), -3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/unary_matmul_engine.md
Name: unary_matmul_engine

Overview:
- Parametrised successor of the temporal-unary 2-bit systolic matrix unit.
- Computes C = A x B, or C = C + A x B, for a rectangular signed A (M x K) and B (K x N) on a K x N weight-stationary array.
- Each A element is streamed as a thermometer (unary) pulse train of its magnitude. Each node ANDs the pulse train with its B magnitude and accumulates sign-corrected. Partial sums move down the array once per window.
- Everything runs on the single clock (no derived clocks). It sits behind a start/busy/done handshake so a controller can issue back-to-back jobs.

Parameters:
- M, 2, rows of A / rows of C
- K, 2, columns of A = rows of B (array height)
- N, 2, columns of B / columns of C (array width)
- BW, 4, operand width, signed two's complement
- W (local), 2**(BW-1), cycles per unary window (covers magnitude of -2**(BW-1))
- OUT_W (local), 2*BW+$clog2(K), signed result width; never overflows
- LAT (local), (M+K+N-2)*W+1, cycles from start acceptance to done

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  job request; accepted only in IDLE
- acc  in  1  sampled with start: 1 = add to held C, 0 = overwrite C
- a_in  in  M*K*BW  A[m][k] at bits [(m*K+k)*BW +: BW]
- b_in  in  K*N*BW  B[k][n] at bits [(k*N+n)*BW +: BW]
- busy  out  1  high while a job is in flight
- done  out  1  one-cycle pulse when c_out is updated
- c_out  out  M*N*OUT_W  C[m][n] at bits [(m*N+n)*OUT_W +: OUT_W]; held between jobs

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, c_out=0, all node accumulators, pipeline registers and counters = 0.
- IDLE state:
  - On the clk edge where start=1, the block captures a_in, b_in and acc into registers, clears the window counters, and goes to RUN. busy=1 from the next cycle.
  - a_in, b_in and acc are don't-care after capture.
- RUN state:
  - cyc counter runs 0..W-1. win counter is 0..M+K+N-3 and increments when cyc wraps.
  - Row-k stream source at window w: A[w-k][k] if 0 <= w-k < M, else magnitude 0.
  - Unary bit = (cyc < |a|), with |a| held as a BW-bit unsigned value so |-2**(BW-1)| = W.
  - Unary bits and A sign bits advance one node right per W cycles (one window), so node (k,n) handles A row m in window m+k+n.
  - Node (k,n), each cycle: acc_node += unary ? ±|B[k][n]| : 0. The sign is negative iff sign(a) xor sign(B) and both operands are nonzero.
  - At each window boundary, node (k,n) passes (partial-in + acc_node) down to row k+1 and clears acc_node. Row 0 partial-in = 0.
  - Bottom row output at the end of window m+K-1+n is C[m][n]. It is written into c_out: value if the captured acc=0, c_out+value if acc=1, modulo 2**OUT_W.
- Leaving RUN: after exactly LAT cycles in RUN, state goes to IDLE, busy=0 and done=1 for one cycle. c_out is final on that same cycle.
- Intermediate c_out: c_out elements may update while busy=1. Consumers sample c_out only on done.
- Handshake edge cases:
  - start while busy is ignored (not queued).
  - start on the done cycle is accepted (back-to-back); done and busy may both read 1 in that cycle only in the sense that busy rises on the next cycle.
- Operand corner cases:
  - Zero operands produce no pulses and a zero contribution.
  - -2**(BW-1) x -2**(BW-1) = +2**(2BW-2); this is exact within OUT_W.
- Reset mid-job aborts immediately: c_out returns to 0 and no done is issued.
- Arithmetic: all internal sums are OUT_W-bit signed. Magnitude conversion is two's-complement negate into BW bits.

Test Plan:
- Basic product: M=K=N=2, BW=4, A=[[1,2],[3,4]], B=[[5,6],[7,-8]], acc=0, start 1 cycle -> done exactly 33 cycles after the accept edge (LAT = 4*8+1), c_out=[[19,-10],[43,-14]], busy high for 33 cycles.
- Extreme values: A all -8, B all -8 -> every C = 128 (no overflow with OUT_W=9). Then A all -8, B all 7 -> every C = -112.
- Accumulate: rerun the basic operands with acc=1 -> c_out=[[38,-20],[86,-28]]. Rerun again with acc=0 -> back to [[19,-10],[43,-14]].
- Handshake: pulse start at busy cycle 10 with different operands -> ignored, result unchanged. Assert start in the done cycle -> second job accepted, second done 33 cycles later.
- Reset mid-job: assert reset at busy cycle 15 -> busy=0, c_out=0, no done. A fresh job afterwards gives the correct result.
- Rectangular and zeros: M=3, K=2, N=1, A=[[0,0],[1,-1],[-8,7]], B=[[3],[3]] -> c_out=[[0],[0],[-3]], done after (3+2+1-2)*8+1 = 33 cycles.
